csr_counter_unit: RTL
=====================

Name: csr_counter_unit

Overview:
Parametrised machine/supervisor performance-counter CSR block sitting beside the trap/status CSR file.
- Implements mcycle, minstret, NUM_HPM programmable hpm counters, mhpmevent selectors, mcountinhibit, mcounteren and scounteren.
- Provides the user-level read-only aliases (cycle/instret/hpmcounterN) with per-privilege access checking.
- Writes arrive from WB; reads are served combinationally to ID.
- Adds a counter-overflow interrupt request for the interrupt arbiter.

Parameters:
- XLEN, 64, CSR data width.
- CNT_W, 64, physical counter width (1..XLEN); reads zero-extend to XLEN.
- NUM_HPM, 4, implemented hpm counters starting at index 3 (0..29).
- NUM_EVENTS, 8, width of event_in; mhpmevent[NUM_EVENTS-1:0] is the event mask.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- csr_we_wb  in  1  CSR write strobe from WB
- csr_addr_wb  in  12  WB write address
- csr_val_wb  in  XLEN  WB write data
- csr_addr_id  in  12  ID read address
- priv  in  2  current privilege (3=M, 1=S, 0=U)
- csr_val_id  out  XLEN  read data
- csr_hit_id  out  1  csr_addr_id decodes to this unit
- csr_illegal_id  out  1  read access denied at current priv
- retire_wb  in  1  one instruction retired this cycle
- event_in  in  NUM_EVENTS  per-cycle event pulses
- ovf_int  out  1  counter-overflow interrupt request (cause 13)
- cosim_mcycle  out  XLEN  mcycle value
- cosim_minstret  out  XLEN  minstret value

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset all counters, mhpmevent, mcountinhibit, mcounteren and scounteren are 0, and ovf_int=0.
- Address map:
  - mcycle 0xB00; minstret 0xB02; mhpmcounterK 0xB00+K (K=3..31).
  - mcountinhibit 0x320; mhpmeventK 0x320+K.
  - mcounteren 0x306; scounteren 0x106.
  - Aliases: cycle 0xC00, instret 0xC02, hpmcounterK 0xC00+K.
  - 0xB01, 0xC01 and 0x321 (time) are not hits.
- Unimplemented K (K>=3+NUM_HPM): hit, legal, read 0, writes ignored.
- Increments, evaluated every cycle:
  - mcycle += 1 unless mcountinhibit[0].
  - minstret += retire_wb unless mcountinhibit[2].
  - hpmK += 1 when |(event_in & mhpmeventK mask) and not mcountinhibit[K].
  - Max one increment per counter per cycle.
- Wrap: counter at 2^CNT_W-1 increments to 0.
- Simultaneous write and increment to the same counter: the written value (truncated to CNT_W) is loaded and no increment occurs that cycle. The write is visible to an ID read on the next cycle; there is no forwarding.
- Writable masks:
  - mcountinhibit bit1 is hardwired 0; bits above 3+NUM_HPM-1 read 0.
  - mcounteren/scounteren: bits [2:0] and implemented hpm bits are writable; others read 0.
  - mhpmevent: mask bits plus bit XLEN-1 (OF, see feature); others read 0.
- Alias addresses (0xCxx) are read-only; csr_we_wb to them is ignored (the illegal-write trap is raised by the decoder).
- Read access for counter index k:
  - priv=3: always legal.
  - priv=1: legal iff mcounteren[k].
  - priv=0: legal iff mcounteren[k] & scounteren[k].
- Any 0xBxx or 0x3xx address at priv<3 is illegal; scounteren at priv=0 is illegal.
- Illegal: csr_illegal_id=1, csr_val_id=0.
- Non-hit: csr_hit_id=0, csr_illegal_id=0, csr_val_id=0.
- Reads are purely combinational from current register state.

Optional Feature:
- Macro HPM_OVF_EN, defined:
  - When an hpmK wraps via increment, OF (mhpmeventK[XLEN-1]) sets.
  - OF is sticky until software writes the bit to 0; a software write of 1 also sets it.
  - A wrap coinciding with a write to mhpmeventK: the write value wins.
  - ovf_int is registered, OR of all OF bits; it is asserted the cycle after OF sets.
- Macro undefined: OF reads 0, is not writable, and ovf_int is tied to 0.
- mcycle and minstret never set OF in either build.

Test Plan:
- Reset, run 10 cycles with no inhibit, priv=3, read 0xB00 -> 10; read 0xB02 with retire_wb high 4 of those cycles -> 4.
- Write mcountinhibit=0x1, hold 5 cycles -> mcycle unchanged; write 0 -> resumes incrementing next cycle.
- Write mhpmevent3=0x5, drive event_in=0x4 for 3 cycles and 0x2 for 2 cycles -> hpmcounter3=3; same-cycle write mhpmcounter3=100 with event -> reads 100.
- priv=1, mcounteren=0 -> read 0xC00 gives illegal=1, val 0; mcounteren=1 -> legal, val=mcycle; priv=0 with scounteren=0 -> illegal.
- HPM_OVF_EN, CNT_W=8: mhpmcounter3=0xFF, one event -> counter 0, OF=1, ovf_int=1 next cycle; write mhpmevent3 with OF=0 -> ovf_int=0 the cycle after.
- Read 0xB1F with NUM_HPM=4 -> hit=1, val 0; read 0xC01 -> hit=0.

Source files
------------

// File: rtl/csr_counter_unit.sv
// Machine/supervisor performance-counter CSR block: mcycle, minstret, hpm counters, event selectors,
// inhibit and counter-enable registers, user aliases. Optional HPM_OVF_EN: sticky OF bits and ovf_int.
module csr_counter_unit #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned CNT_W      = 64,
   parameter int unsigned NUM_HPM    = 4,
   parameter int unsigned NUM_EVENTS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  csr_we_wb,
   input  logic [11:0]           csr_addr_wb,
   input  logic [XLEN-1:0]       csr_val_wb,
   input  logic [11:0]           csr_addr_id,
   input  logic [1:0]            priv,
   output logic [XLEN-1:0]       csr_val_id,
   output logic                  csr_hit_id,
   output logic                  csr_illegal_id,
   input  logic                  retire_wb,
   input  logic [NUM_EVENTS-1:0] event_in,
   output logic                  ovf_int,
   output logic [XLEN-1:0]       cosim_mcycle,
   output logic [XLEN-1:0]       cosim_minstret
);
   localparam int unsigned     NCNT     = 3 + NUM_HPM;
   localparam int unsigned     HPM_N    = (NUM_HPM > 0) ? NUM_HPM : 1;
   localparam logic [NCNT-1:0] INH_MASK = ~(NCNT'(2));

   logic [CNT_W-1:0]      cnt_q [NCNT];
   logic [CNT_W-1:0]      cnt_d [NCNT];
   logic [NUM_EVENTS-1:0] evt_q [HPM_N];
   logic [NUM_EVENTS-1:0] evt_d [HPM_N];
   logic [HPM_N-1:0]      of_q, of_d;
   logic [NCNT-1:0]       inh_q, inh_d, mcen_q, mcen_d, scen_q, scen_d;
   logic [NCNT-1:0]       inc, wr_cnt;
   logic [HPM_N-1:0]      wr_evt;
   logic                  wr_cblk, wr_eblk;
   logic [4:0]            wr_idx;

   assign wr_idx  = csr_addr_wb[4:0];
   assign wr_cblk = csr_we_wb && (csr_addr_wb[11:5] == 7'h58);
   assign wr_eblk = csr_we_wb && (csr_addr_wb[11:5] == 7'h19);

   // index 1 (time) is never incremented or written
   always_comb begin
      inc       = '0;
      wr_cnt    = '0;
      wr_evt    = '0;
      inc[0]    = ~inh_q[0];
      inc[2]    = retire_wb & ~inh_q[2];
      wr_cnt[0] = wr_cblk && (wr_idx == 5'd0);
      wr_cnt[2] = wr_cblk && (wr_idx == 5'd2);
      for (int unsigned k = 0; k < NUM_HPM; k++) begin
         inc[3+k]    = (|(event_in & evt_q[k])) & ~inh_q[3+k];
         wr_cnt[3+k] = wr_cblk && (wr_idx == 5'(3 + k));
         wr_evt[k]   = wr_eblk && (wr_idx == 5'(3 + k));
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      evt_d = evt_q;
      of_d  = of_q;
      for (int unsigned k = 0; k < NCNT; k++) begin
         if (wr_cnt[k])   cnt_d[k] = csr_val_wb[CNT_W-1:0];
         else if (inc[k]) cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
      for (int unsigned k = 0; k < NUM_HPM; k++) begin
         if (wr_evt[k]) evt_d[k] = csr_val_wb[NUM_EVENTS-1:0];
`ifdef HPM_OVF_EN
         // a write to mhpmevent overrides a same-cycle wrap
         if (wr_evt[k])
            of_d[k] = csr_val_wb[XLEN-1];
         else if (inc[3+k] && !wr_cnt[3+k] && (&cnt_q[3+k]))
            of_d[k] = 1'b1;
`endif
      end
      inh_d  = (csr_we_wb && csr_addr_wb == 12'h320) ? (csr_val_wb[NCNT-1:0] & INH_MASK) : inh_q;
      mcen_d = (csr_we_wb && csr_addr_wb == 12'h306) ? csr_val_wb[NCNT-1:0] : mcen_q;
      scen_d = (csr_we_wb && csr_addr_wb == 12'h106) ? csr_val_wb[NCNT-1:0] : scen_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '{default: '0};
         evt_q  <= '{default: '0};
         of_q   <= '0;
         inh_q  <= '0;
         mcen_q <= '0;
         scen_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         evt_q  <= evt_d;
         of_q   <= of_d;
         inh_q  <= inh_d;
         mcen_q <= mcen_d;
         scen_q <= scen_d;
      end
   end

`ifdef HPM_OVF_EN
   logic ovf_q;
   always_ff @(posedge clk) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= |of_q;
   end
   assign ovf_int = ovf_q;
`else
   assign ovf_int = 1'b0;
`endif

   assign cosim_mcycle   = XLEN'(cnt_q[0]);
   assign cosim_minstret = XLEN'(cnt_q[2]);

   logic [4:0]      rd_idx;
   logic [31:0]     mcen_x, scen_x;
   logic            hit, legal;
   logic [XLEN-1:0] rval;

   assign rd_idx = csr_addr_id[4:0];
   assign mcen_x = 32'(mcen_q);
   assign scen_x = 32'(scen_q);

   always_comb begin
      hit   = 1'b0;
      legal = 1'b0;
      rval  = '0;
      if (csr_addr_id[11:5] == 7'h58 && rd_idx != 5'd1) begin
         hit   = 1'b1;
         legal = (priv == 2'd3);
         for (int unsigned k = 0; k < NCNT; k++)
            if (rd_idx == 5'(k)) rval = XLEN'(cnt_q[k]);
      end else if (csr_addr_id[11:5] == 7'h60 && rd_idx != 5'd1) begin
         hit = 1'b1;
         case (priv)
            2'd3:    legal = 1'b1;
            2'd0:    legal = mcen_x[rd_idx] & scen_x[rd_idx];
            default: legal = mcen_x[rd_idx];
         endcase
         for (int unsigned k = 0; k < NCNT; k++)
            if (rd_idx == 5'(k)) rval = XLEN'(cnt_q[k]);
      end else if (csr_addr_id[11:5] == 7'h19 && rd_idx >= 5'd3) begin
         hit   = 1'b1;
         legal = (priv == 2'd3);
         for (int unsigned k = 0; k < NUM_HPM; k++)
            if (rd_idx == 5'(3 + k)) begin
               rval         = XLEN'(evt_q[k]);
               rval[XLEN-1] = of_q[k];
            end
      end else if (csr_addr_id == 12'h320) begin
         hit   = 1'b1;
         legal = (priv == 2'd3);
         rval  = XLEN'(inh_q);
      end else if (csr_addr_id == 12'h306) begin
         hit   = 1'b1;
         legal = (priv == 2'd3);
         rval  = XLEN'(mcen_q);
      end else if (csr_addr_id == 12'h106) begin
         hit   = 1'b1;
         legal = (priv != 2'd0);
         rval  = XLEN'(scen_q);
      end
   end

   assign csr_hit_id     = hit;
   assign csr_illegal_id = hit & ~legal;
   assign csr_val_id     = (hit && legal) ? rval : '0;

endmodule
